// File: rtl/ex_arith_div.sv
// Execute-stage arithmetic unit: single-cycle add/sub/compare plus an iterative
// restoring DIV/DIVU engine that stalls the pipeline and writes HI/LO.
module ex_arith_div #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        aluop_i,
  input  logic [2:0]        alusel_i,
  input  logic [WIDTH-1:0]  reg1_i,
  input  logic [WIDTH-1:0]  reg2_i,
  input  logic [ADDR_W-1:0] wd_i,
  input  logic              wreg_i,
  input  logic              flush_i,
  output logic [ADDR_W-1:0] wd_o,
  output logic              wreg_o,
  output logic [WIDTH-1:0]  wdata_o,
  output logic              ovf_o,
  output logic              whilo_o,
  output logic [WIDTH-1:0]  hi_o,
  output logic [WIDTH-1:0]  lo_o,
  output logic              stallreq_o
);

  localparam logic [7:0] EXE_ADD_OP  = 8'b0010_0000;
  localparam logic [7:0] EXE_ADDU_OP = 8'b0010_0001;
  localparam logic [7:0] EXE_SUB_OP  = 8'b0010_0010;
  localparam logic [7:0] EXE_SUBU_OP = 8'b0010_0011;
  localparam logic [7:0] EXE_SLT_OP  = 8'b0010_1010;
  localparam logic [7:0] EXE_SLTU_OP = 8'b0010_1011;
  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;
  localparam logic [2:0] EXE_RES_ARITHMETIC = 3'b100;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] quo, dvs, rem;
  logic [WIDTH-1:0] hi_r, lo_r;
  logic [CNT_W-1:0] cnt;
  logic             neg_q, neg_r;

  logic             is_div, is_sdiv, ovf, active;
  logic [WIDTH-1:0] sum, diff, result, a_abs, b_abs;

  assign is_sdiv = (aluop_i == EXE_DIV_OP);
  assign is_div  = is_sdiv || (aluop_i == EXE_DIVU_OP);
  assign sum     = reg1_i + reg2_i;
  assign diff    = reg1_i - reg2_i;

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (aluop_i)
      EXE_ADDU_OP: result = sum;
      EXE_SUBU_OP: result = diff;
      EXE_ADD_OP: begin
        result = sum;
        ovf    = (reg1_i[WIDTH-1] == reg2_i[WIDTH-1]) && (sum[WIDTH-1] != reg1_i[WIDTH-1]);
      end
      EXE_SUB_OP: begin
        result = diff;
        ovf    = (reg1_i[WIDTH-1] != reg2_i[WIDTH-1]) && (diff[WIDTH-1] != reg1_i[WIDTH-1]);
      end
      EXE_SLT_OP:  result = {{(WIDTH-1){1'b0}}, ($signed(reg1_i) < $signed(reg2_i))};
      EXE_SLTU_OP: result = {{(WIDTH-1){1'b0}}, (reg1_i < reg2_i)};
      default: ;
    endcase
  end

  // Magnitudes for signed divide; the most-negative value maps to itself,
  // which is the correct unsigned magnitude.
  assign a_abs = (is_sdiv && reg1_i[WIDTH-1]) ? -reg1_i : reg1_i;
  assign b_abs = (is_sdiv && reg2_i[WIDTH-1]) ? -reg2_i : reg2_i;

  // One restoring step: dividend bits shift out of quo into rem, quotient
  // bits shift into quo from the bottom.
  logic [WIDTH:0]   rem_sh, trial;
  logic             take;
  logic [WIDTH-1:0] rem_nx, quo_nx;

  assign rem_sh = {rem, quo[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, dvs};
  assign take   = ~trial[WIDTH];
  assign rem_nx = take ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_nx = {quo[WIDTH-2:0], take};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      quo   <= '0;
      dvs   <= '0;
      rem   <= '0;
      cnt   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      hi_r  <= '0;
      lo_r  <= '0;
    end else if (flush_i) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (is_div) begin
          if (reg2_i == '0) begin
            hi_r  <= reg1_i;
            lo_r  <= '1;
            state <= S_DONE;
          end else begin
            quo   <= a_abs;
            dvs   <= b_abs;
            rem   <= '0;
            cnt   <= '0;
            neg_q <= is_sdiv && (reg1_i[WIDTH-1] ^ reg2_i[WIDTH-1]);
            neg_r <= is_sdiv && reg1_i[WIDTH-1];
            state <= S_CALC;
          end
        end
        S_CALC: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH-1)) begin
            lo_r  <= neg_q ? -quo_nx : quo_nx;
            hi_r  <= neg_r ? -rem_nx : rem_nx;
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Reset forces every output low, including the pass-through fields.
  assign active     = rst && !flush_i;
  assign stallreq_o = active && (((state == S_IDLE) && is_div) || (state == S_CALC));
  assign whilo_o    = active && (state == S_DONE);
  assign wd_o       = rst ? wd_i : '0;
  assign wreg_o     = active && wreg_i && !ovf && !is_div;
  assign wdata_o    = (rst && !is_div && (alusel_i == EXE_RES_ARITHMETIC)) ? result : '0;
  assign ovf_o      = rst && ovf;
  assign hi_o       = hi_r;
  assign lo_o       = lo_r;

endmodule

// File: tb/tb_ex_arith_div.sv
// Directed bench for ex_arith_div: single-cycle ops, divide latency/results,
// divide by zero, back-to-back divides, flush and reset aborts.
module tb_ex_arith_div;
  localparam int W = 32;
  localparam logic [7:0] OP_ADD  = 8'b0010_0000;
  localparam logic [7:0] OP_ADDU = 8'b0010_0001;
  localparam logic [7:0] OP_SUB  = 8'b0010_0010;
  localparam logic [7:0] OP_SUBU = 8'b0010_0011;
  localparam logic [7:0] OP_SLT  = 8'b0010_1010;
  localparam logic [7:0] OP_SLTU = 8'b0010_1011;
  localparam logic [7:0] OP_DIV  = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU = 8'b0001_1011;
  localparam logic [7:0] OP_NOP  = 8'b0000_0000;
  localparam logic [2:0] SEL_AR  = 3'b100;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   aluop_i;
  logic [2:0]   alusel_i;
  logic [W-1:0] reg1_i, reg2_i;
  logic [4:0]   wd_i;
  logic         wreg_i, flush_i;
  logic [4:0]   wd_o;
  logic         wreg_o, ovf_o, whilo_o, stallreq_o;
  logic [W-1:0] wdata_o, hi_o, lo_o;

  int n_checks = 0;
  int n_fail   = 0;

  ex_arith_div #(.WIDTH(W), .ADDR_W(5), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .flush_i(flush_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .ovf_o(ovf_o), .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o),
    .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    aluop_i  = op;
    alusel_i = SEL_AR;
    reg1_i   = a;
    reg2_i   = b;
    wd_i     = 5'd3;
    wreg_i   = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush_i = 1'b0;
    present(OP_ADDU, 32'd5, 32'd7);
    #2;
    n_checks++;
    if ({wd_o, wreg_o, wdata_o, ovf_o, whilo_o, hi_o, lo_o, stallreq_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got wd=%0d wreg=%0b wdata=%h ovf=%0b whilo=%0b hi=%h lo=%h stall=%0b, want all 0",
               wd_o, wreg_o, wdata_o, ovf_o, whilo_o, hi_o, lo_o, stallreq_o);
    end
    nxt(); nxt();
    rst = 1'b1;
  endtask

  task automatic test_single_cycle();
    logic [7:0]   ops [7] = '{OP_SUBU, OP_SUB, OP_ADD, OP_SLT, OP_SLTU, OP_ADDU, OP_SUBU};
    logic [W-1:0] as  [7] = '{32'd5, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd9};
    logic [W-1:0] bs  [7] = '{32'd7, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd4};
    logic [W-1:0] ew  [7] = '{32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'h8000_0000, 32'd1, 32'd0, 32'h8000_0000, 32'd0};
    logic         eo  [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      nxt();
      present(ops[i], as[i], bs[i]);
      if (i == 6) alusel_i = 3'b001;  // non-arithmetic class gives no data
      @(negedge clk);
      n_checks++;
      if (wdata_o !== ew[i] || ovf_o !== eo[i] || wreg_o !== !eo[i] || wd_o !== 5'd3 || stallreq_o !== 1'b0) begin
        n_fail++;
        $display("FAIL single_op[%0d]: got wdata=%h ovf=%0b wreg=%0b wd=%0d stall=%0b, want wdata=%h ovf=%0b wreg=%0b wd=3 stall=0",
                 i, wdata_o, ovf_o, wreg_o, wd_o, stallreq_o, ew[i], eo[i], !eo[i]);
      end
    end
  endtask

  task automatic test_divide();
    logic [7:0]   ops [5] = '{OP_DIVU, OP_DIV, OP_DIV, OP_DIVU, OP_DIV};
    logic [W-1:0] as  [5] = '{32'd100, 32'hFFFF_FFF9, 32'h8000_0000, 32'd9, 32'hFFFF_FFF9};
    logic [W-1:0] bs  [5] = '{32'd7, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [W-1:0] eh  [5] = '{32'd2, 32'hFFFF_FFFF, 32'd0, 32'd9, 32'hFFFF_FFF9};
    logic [W-1:0] el  [5] = '{32'd14, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    int           last[5] = '{33, 33, 33, 1, 1};
    for (int i = 0; i < 5; i++) begin
      nxt();
      present(ops[i], as[i], bs[i]);
      for (int c = 0; c <= last[i]; c++) begin
        @(negedge clk);
        n_checks++;
        if (stallreq_o !== (c < last[i]) || whilo_o !== (c == last[i]) || wreg_o !== 1'b0 || wdata_o !== '0) begin
          n_fail++;
          $display("FAIL div[%0d]_cycle%0d: got stall=%0b whilo=%0b wreg=%0b wdata=%h, want stall=%0b whilo=%0b wreg=0 wdata=0",
                   i, c, stallreq_o, whilo_o, wreg_o, wdata_o, (c < last[i]), (c == last[i]));
        end
        if (c == last[i]) begin
          n_checks++;
          if (hi_o !== eh[i] || lo_o !== el[i]) begin
            n_fail++;
            $display("FAIL div[%0d]_result: got hi=%h lo=%h, want hi=%h lo=%h", i, hi_o, lo_o, eh[i], el[i]);
          end
        end else @(posedge clk);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] as[2] = '{32'd100, 32'd50};
    logic [W-1:0] bs[2] = '{32'd7, 32'd5};
    logic [W-1:0] eh[2] = '{32'd2, 32'd0};
    logic [W-1:0] el[2] = '{32'd14, 32'd10};
    for (int i = 0; i < 2; i++) begin
      nxt();
      present(OP_DIVU, as[i], bs[i]);
      for (int c = 0; c <= 33; c++) begin
        @(negedge clk);
        n_checks++;
        if (stallreq_o !== (c < 33) || whilo_o !== (c == 33)) begin
          n_fail++;
          $display("FAIL b2b[%0d]_cycle%0d: got stall=%0b whilo=%0b, want stall=%0b whilo=%0b",
                   i, c, stallreq_o, whilo_o, (c < 33), (c == 33));
        end
        if (c == 33) begin
          n_checks++;
          if (hi_o !== eh[i] || lo_o !== el[i]) begin
            n_fail++;
            $display("FAIL b2b[%0d]_result: got hi=%h lo=%h, want hi=%h lo=%h", i, hi_o, lo_o, eh[i], el[i]);
          end
        end else @(posedge clk);
      end
    end
  endtask

  task automatic test_flush();
    int pulses = 0;
    int stalls = 0;
    nxt();
    present(OP_DIVU, 32'd100, 32'd7);
    for (int c = 1; c <= 10; c++) nxt();
    flush_i = 1'b1;
    @(negedge clk);
    n_checks++;
    if (stallreq_o !== 1'b0 || whilo_o !== 1'b0 || wreg_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_cycle: got stall=%0b whilo=%0b wreg=%0b, want 0 0 0", stallreq_o, whilo_o, wreg_o);
    end
    nxt();
    flush_i = 1'b0;
    aluop_i = OP_NOP;
    for (int c = 11; c <= 45; c++) begin
      @(negedge clk);
      if (whilo_o) pulses++;
      if (stallreq_o) stalls++;
      @(posedge clk);
    end
    n_checks++;
    if (pulses !== 0 || stalls !== 0) begin
      n_fail++;
      $display("FAIL flush_after: got %0d whilo pulses %0d stall cycles, want 0 0", pulses, stalls);
    end
  endtask

  task automatic test_reset_mid_div();
    int pulses = 0;
    int stalls = 0;
    #1;
    present(OP_DIVU, 32'd100, 32'd7);
    for (int c = 1; c <= 20; c++) nxt();
    rst = 1'b0;
    #1;
    n_checks++;
    if ({wd_o, wreg_o, wdata_o, ovf_o, whilo_o, hi_o, lo_o, stallreq_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_div: got wd=%0d wreg=%0b wdata=%h ovf=%0b whilo=%0b hi=%h lo=%h stall=%0b, want all 0",
               wd_o, wreg_o, wdata_o, ovf_o, whilo_o, hi_o, lo_o, stallreq_o);
    end
    nxt();
    rst = 1'b1;
    aluop_i = OP_NOP;
    for (int c = 21; c <= 45; c++) begin
      @(negedge clk);
      if (whilo_o) pulses++;
      if (stallreq_o) stalls++;
      @(posedge clk);
    end
    n_checks++;
    if (pulses !== 0 || stalls !== 0 || hi_o !== '0 || lo_o !== '0) begin
      n_fail++;
      $display("FAIL reset_after: got %0d pulses %0d stalls hi=%h lo=%h, want 0 0 0 0", pulses, stalls, hi_o, lo_o);
    end
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_divide();
    test_back_to_back();
    test_flush();
    test_reset_mid_div();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_arith_div.md
Name: ex_arith_div

Overview:
- Parametrised execute-stage arithmetic unit for the 5-stage MIPS pipeline.
- Generalises the single-op SUBU execute block in three ways:
  - adds ADDU/ADD/SUBU/SUB/SLT/SLTU as single-cycle operations;
  - adds signed overflow detection;
  - adds an iterative DIV/DIVU engine that writes HI/LO and stalls the pipeline via stallreq_o.
- Sits between id_ex and ex_mem; drives the register-write and HI/LO-write paths.

Parameters:
- WIDTH, 32, operand/result width in bits (≥4, even).
- ADDR_W, 5, register-file address width.
- CNT_W, 6, divider iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- aluop_i  in  8  operation code, `EXE_*_OP from the shared defines.
- alusel_i  in  3  result-class select; only `EXE_RES_ARITHMETIC produces data.
- reg1_i  in  WIDTH  operand A / dividend.
- reg2_i  in  WIDTH  operand B / divisor.
- wd_i  in  ADDR_W  destination register.
- wreg_i  in  1  destination write enable.
- flush_i  in  1  abort current instruction (exception/branch flush).
- wd_o  out  ADDR_W  passed-through destination.
- wreg_o  out  1  register write enable.
- wdata_o  out  WIDTH  register write data.
- ovf_o  out  1  signed overflow on ADD/SUB (exception request).
- whilo_o  out  1  HI/LO write strobe.
- hi_o  out  WIDTH  HI write data (remainder).
- lo_o  out  WIDTH  LO write data (quotient).
- stallreq_o  out  1  request pipeline stall.

Behaviour:
- Reset (rst=0, async): FSM=IDLE, counter=0, internal registers 0; every output is 0.
- Single-cycle ops (combinational from inputs, state IDLE):
  - ADDU/SUBU: modulo 2^WIDTH sum/difference.
  - ADD/SUB: same result; ovf_o=1 when the operands' signs give a signed overflow (sum of same-sign operands flips sign; difference of opposite-sign operands flips sign). When ovf_o=1, wreg_o is forced 0.
  - SLT: signed compare A<B gives 1, else 0, zero-extended. SLTU: the same, unsigned.
  - Any other aluop_i: internal result 0, ovf_o=0.
- wdata_o = result if alusel_i==`EXE_RES_ARITHMETIC, else 0.
- wd_o = wd_i always. wreg_o = wreg_i unless forced 0.
- DIV/DIVU never write the GPR file: wreg_o=0, wdata_o=0.
- FSM states IDLE, CALC, DONE:
  - IDLE, aluop_i is DIV/DIVU, flush_i=0:
    - stallreq_o=1.
    - Latch |A|, |B| for DIV (raw operands for DIVU).
    - Latch the sign flags: quotient negative = signA XOR signB; remainder negative = signA.
    - If reg2_i==0, go to DONE. Otherwise clear the counter and go to CALC.
  - CALC:
    - stallreq_o=1.
    - One restoring radix-2 step per cycle: shift the partial remainder, trial-subtract, set the quotient bit.
    - After exactly WIDTH steps, go to DONE.
  - DONE:
    - stallreq_o=0 and whilo_o=1 for exactly one cycle.
    - Apply sign correction for DIV; hi_o/lo_o are registered values.
    - Next state IDLE unconditionally, even if aluop_i still shows the divide.
    - The next divide is accepted only when a new instruction is presented in IDLE.
- Divide by zero: lo_o = all ones, hi_o = reg1_i (unsigned, unmodified); total stall is 1 cycle.
- Latency: a divide presented in cycle T has stallreq_o high in T through T+WIDTH, and whilo_o high in T+WIDTH+1.
- The pipeline holds all *_i inputs stable while stallreq_o=1. Operands are latched at start, so input changes during CALC are ignored.
- Most-negative / -1 under DIV: lo_o = most-negative value (wraps), hi_o = 0, no exception.
- flush_i=1 in any state:
  - stallreq_o=0, whilo_o=0, wreg_o=0 that cycle.
  - FSM goes to IDLE at the next edge; a partial divide is discarded.
- Reset asserted mid-divide: immediate return to IDLE with all outputs 0; no HI/LO write.

Test Plan:
- WIDTH=32, SUBU 5−7, wreg_i=1, wd_i=3 -> wdata_o=0xFFFFFFFE, wreg_o=1, wd_o=3, ovf_o=0, stallreq_o=0.
- SUB 0x80000000−1, then ADD 0x7FFFFFFF+1 -> ovf_o=1, wreg_o=0 for both. Also SLT 0xFFFFFFFF,1 -> 1 and SLTU 0xFFFFFFFF,1 -> 0.
- DIVU 100/7 in cycle 0 -> stallreq_o=1 for cycles 0–32, whilo_o=1 in cycle 33 with hi_o=2, lo_o=14, wreg_o=0; stallreq_o=0 in cycle 33.
- DIV 0xFFFFFFF9(−7)/2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo_o=0x80000000, hi_o=0.
- DIVU 9/0 -> stallreq_o=1 one cycle, next cycle whilo_o=1, lo_o=0xFFFFFFFF, hi_o=9. Back-to-back DIVU 100/7 then DIVU 50/5 -> two separate 34-cycle sequences, second gives lo_o=10, hi_o=0.
- Two abort cases on DIVU 100/7:
  - Assert flush_i in cycle 10 -> stallreq_o=0 that cycle, FSM back in IDLE at cycle 11, no whilo_o pulse.
  - Pull rst low in cycle 20 -> all outputs 0 immediately, no whilo_o pulse.
